// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave for the 3Kx32 single-port data SRAM: zero-wait reads and writes through a
// one-entry write buffer with read forwarding; transfers wider than a word get a two-cycle ERROR.
module ahb_sram_bridge #(
  parameter int AW = 12
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic [31:0]   HRDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  input  logic [31:0]   SRAMRDATA,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic          SRAMCS0,
  output logic [AW-1:0] SRAMADDR
);

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;

  state_t        state_q, state_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    mask_q, mask_d, mask_now;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [3:0]    wb_be_q, wb_be_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          wb_load;
  logic          accept, size_err, acc_ok, rd_acc;
  logic [AW-1:0] haddr_word;
  logic [31:0]   fwd_data;
  logic          unused_bits;

  assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};
  assign haddr_word  = HADDR[AW+1:2];
  assign accept      = HSEL & HTRANS[1] & HREADY;
  assign size_err    = (HSIZE > 3'd2);
  assign acc_ok      = accept & ~size_err;
  assign rd_acc      = acc_ok & ~HWRITE;

  always_comb begin
    mask_now = 4'b1111;
    case (HSIZE)
      3'd0:    mask_now = 4'b0001 << HADDR[1:0];
      3'd1:    mask_now = 4'b0011 << {HADDR[1], 1'b0};
      default: mask_now = 4'b1111;
    endcase
  end

  // Phase registers only advance when the bus advances; an errored transfer leaves them clear.
  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    addr_d = addr_q;
    mask_d = mask_q;
    if (HREADY) begin
      rd_d   = rd_acc;
      wr_d   = acc_ok & HWRITE;
      addr_d = acc_ok ? haddr_word : '0;
      mask_d = acc_ok ? mask_now : '0;
    end
  end

  always_comb begin
    SRAMCS0    = 1'b0;
    SRAMWEN    = 4'b0000;
    SRAMADDR   = '0;
    SRAMWDATA  = '0;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_be_d    = wb_be_q;
    wb_data_d  = wb_data_q;
    wb_load    = 1'b0;
    if (rd_acc) begin
      SRAMCS0  = 1'b1;
      SRAMADDR = haddr_word;
      if (wr_q) begin
        wb_load    = 1'b1;
        wb_valid_d = 1'b1;
        wb_addr_d  = addr_q;
        wb_be_d    = mask_q;
        wb_data_d  = HWDATA;
      end
    end else if (wb_valid_q) begin
      SRAMCS0    = 1'b1;
      SRAMWEN    = wb_be_q;
      SRAMADDR   = wb_addr_q;
      SRAMWDATA  = wb_data_q;
      wb_valid_d = 1'b0;
    end else if (wr_q) begin
      SRAMCS0   = 1'b1;
      SRAMWEN   = mask_q;
      SRAMADDR  = addr_q;
      SRAMWDATA = HWDATA;
    end
    if (HRESET) begin
      SRAMCS0   = 1'b0;
      SRAMWEN   = 4'b0000;
      SRAMADDR  = '0;
      SRAMWDATA = '0;
    end
  end

  // The RAM still holds pre-buffer data for this word, so overlay the pending bytes.
  always_comb begin
    fwd_data = SRAMRDATA;
    if (wb_valid_q && (wb_addr_q == addr_q)) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_be_q[i]) fwd_data[8*i +: 8] = wb_data_q[8*i +: 8];
      end
    end
    HRDATA = (rd_q && !HRESET) ? fwd_data : 32'h0;
  end

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      IDLE: state_d = IDLE;
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ERR2;
      end
      ERR2: begin
        HRESP   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept && size_err) state_d = ERR1;
    if (HRESET) begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= IDLE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      mask_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_be_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_be_q    <= wb_be_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // A write data phase always follows a non-read address phase, which drains the buffer first.
  wb_overrun_chk: assert property (@(posedge HCLK) disable iff (HRESET) !(wb_load && wb_valid_q));

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Directed bench for ahb_sram_bridge: stimulus pushes expected read data, a negedge monitor pops and compares.
module tb_ahb_sram_bridge;
  localparam int AW = 12;

  logic          HCLK = 1'b0;
  logic          HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, SRAMCS0;
  logic [31:0]   HADDR, HWDATA, HRDATA, SRAMRDATA, SRAMWDATA;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [3:0]    SRAMWEN;
  logic [AW-1:0] SRAMADDR;

  int checks = 0;
  int errors = 0;
  int nready0 = 0;
  logic [31:0] exp_q[$];
  logic [31:0] nxt_wdata;
  logic        rd_dp = 1'b0;
  logic        s_cs, s_rdy, s_resp;
  logic [3:0]  s_wen;
  logic [31:0] s_addr, s_wdata;

  bit [31:0] mem [0:(1<<AW)-1];

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_sram_bridge #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .SRAMRDATA(SRAMRDATA), .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA),
    .SRAMCS0(SRAMCS0), .SRAMADDR(SRAMADDR)
  );

  // Single-port synchronous RAM: read data appears the cycle after the strobe.
  always @(posedge HCLK) begin
    if (SRAMCS0 === 1'b1) begin
      if (SRAMWEN == 4'b0000) SRAMRDATA <= mem[SRAMADDR];
      else begin
        for (int b = 0; b < 4; b++)
          if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge HCLK)
    rd_dp <= !HRESET && HSEL && HTRANS[1] && HREADY && !HWRITE && (HSIZE <= 3'd2);

  always @(negedge HCLK) begin
    if (HREADYOUT !== 1'b1) nready0++;
    if (rd_dp) begin
      if (exp_q.size() == 0) check("rdata_unexpected", HRDATA, 32'hxxxx_xxxx);
      else check("rdata", HRDATA, exp_q.pop_front());
    end
  end

  task automatic step(input logic v, input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
    HSEL      = v;
    HTRANS    = v ? 2'b10 : 2'b00;
    HWRITE    = w;
    HSIZE     = sz;
    HADDR     = a;
    HWDATA    = nxt_wdata;
    nxt_wdata = (v && w) ? d : 32'h0;
    @(negedge HCLK);
    s_cs    = SRAMCS0;
    s_rdy   = HREADYOUT;
    s_resp  = HRESP;
    s_wen   = SRAMWEN;
    s_addr  = 32'(SRAMADDR);
    s_wdata = SRAMWDATA;
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    step(1'b1, 1'b1, sz, a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    step(1'b1, 1'b0, 3'd2, a, 32'h0);
  endtask

  task automatic idl();
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_hreadyout"}, {31'h0, s_rdy}, 32'h1);
    check({tag, "_hresp"},     {31'h0, s_resp}, 32'h0);
    check({tag, "_cs0"},       {31'h0, s_cs}, 32'h0);
    check({tag, "_wen"},       {28'h0, s_wen}, 32'h0);
    check({tag, "_addr"},      s_addr, 32'h0);
    check({tag, "_wdata"},     s_wdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
    HADDR = 32'h0; HWDATA = 32'h0; nxt_wdata = 32'h0;
    @(posedge HCLK); #1;
    idl();
    check_reset_outs("por");
    HRESET = 1'b0;
    idl();

    // Plain word write then read: direct write, zero-wait read.
    wr(32'h010, 3'd2, 32'hDEADBEEF);
    idl();
    check("t1_cs0",   {31'h0, s_cs}, 32'h1);
    check("t1_wen",   {28'h0, s_wen}, 32'hF);
    check("t1_addr",  s_addr, 32'h4);
    check("t1_wdata", s_wdata, 32'hDEADBEEF);
    rd(32'h010, 32'hDEADBEEF);
    check("t1_rd_wen",  {28'h0, s_wen}, 32'h0);
    check("t1_rd_addr", s_addr, 32'h4);
    idl();
    check("t1_nowait", {31'h0, s_rdy}, 32'h1);

    // Write immediately followed by read of the same word: forwarded from the buffer.
    wr(32'h020, 3'd2, 32'h11223344);
    rd(32'h020, 32'h11223344);
    check("t2_rd_wins_wen",  {28'h0, s_wen}, 32'h0);
    check("t2_rd_wins_addr", s_addr, 32'h8);
    idl();
    check("t2_commit_cs0",   {31'h0, s_cs}, 32'h1);
    check("t2_commit_wen",   {28'h0, s_wen}, 32'hF);
    check("t2_commit_addr",  s_addr, 32'h8);
    check("t2_commit_wdata", s_wdata, 32'h11223344);

    // Byte write into a word, then readback with partial forwarding.
    wr(32'h040, 3'd2, 32'hAABBCCDD);
    wr(32'h042, 3'd0, 32'h00EE0000);
    rd(32'h040, 32'hAAEECCDD);
    idl();
    check("t3_byte_wen",   {28'h0, s_wen}, 32'h4);
    check("t3_byte_addr",  s_addr, 32'h10);
    check("t3_byte_wdata", s_wdata, 32'h00EE0000);

    // Mixed stream W,W,R,R,W,R plus an address that wraps onto word 4.
    n0 = nready0;
    wr(32'h100, 3'd2, 32'h01020304);
    wr(32'h204, 3'd2, 32'hCAFEF00D);
    rd(32'h100, 32'h01020304);
    rd(32'h204, 32'hCAFEF00D);
    wr(32'h102, 3'd1, 32'hBEEF0000);
    rd(32'h100, 32'hBEEF0304);
    idl();
    rd(32'h4010, 32'hDEADBEEF);
    idl();
    check("t4_no_waits", 32'(nready0 - n0), 32'h0);

    // Unsupported size: two-cycle ERROR, no RAM activity, memory untouched.
    wr(32'h000, 3'd3, 32'hFFFFFFFF);
    check("t5_addr_cs0", {31'h0, s_cs}, 32'h0);
    idl();
    check("t5_err1_rdy",  {31'h0, s_rdy}, 32'h0);
    check("t5_err1_resp", {31'h0, s_resp}, 32'h1);
    check("t5_err1_cs0",  {31'h0, s_cs}, 32'h0);
    idl();
    check("t5_err2_rdy",  {31'h0, s_rdy}, 32'h1);
    check("t5_err2_resp", {31'h0, s_resp}, 32'h1);
    check("t5_err2_cs0",  {31'h0, s_cs}, 32'h0);
    idl();
    check("t5_after_resp", {31'h0, s_resp}, 32'h0);
    rd(32'h000, 32'h0);
    idl();

    // Reset with a write still buffered: outputs go quiet and the write is lost.
    // The read's data phase lands in the reset cycle, where HRDATA must be zero.
    wr(32'h040, 3'd2, 32'h12345678);
    rd(32'h040, 32'h0);
    HRESET = 1'b1;
    idl();
    check_reset_outs("midrst");
    HRESET = 1'b0;
    rd(32'h040, 32'hAAEECCDD);
    idl();
    idl();

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
